// File: rtl/fifo_in_arbiter.sv
// Round-robin arbiter that shares one valid/ready FIFO write port among NUM_REQ requesters.
// A grant is held from the first beat of a burst until its last beat, or until MAX_BURST beats have transferred.
module fifo_in_arbiter #(
   parameter  int NUM_REQ   = 4,
   parameter  int DATA_W    = 32,
   parameter  int MAX_BURST = 64,
   localparam int ID_W      = $clog2(NUM_REQ),
   localparam int CNT_W     = $clog2(MAX_BURST + 1)
) (
   input  logic                      clk,
   input  logic                      rstB,
   input  logic [NUM_REQ-1:0]        req_vld,
   input  logic [NUM_REQ*DATA_W-1:0] req_data,
   input  logic [NUM_REQ-1:0]        req_last,
   output logic [NUM_REQ-1:0]        req_rdy,
   output logic [DATA_W-1:0]         out_data,
   output logic                      out_vld,
   input  logic                      out_rdy,
   output logic [ID_W-1:0]           grant_id,
   output logic                      busy,
   output logic                      burst_err
);

   // Valid/ready: a beat moves on a clk edge where valid and ready are both 1.
   // A source must hold data and last stable while valid=1 and ready=0.
   // Ready never waits on valid, so no combinational loop forms through the arbiter.

   typedef enum logic {IDLE, BURST} state_t;

   state_t              state, state_n;
   logic [ID_W-1:0]     rr_ptr, rr_n;
   logic [ID_W-1:0]     grant_n;
   logic [CNT_W-1:0]    beat_cnt, cnt_n;
   logic                err_n;

   logic                pick_found;
   logic [ID_W-1:0]     pick_id;
   logic [ID_W-1:0]     scan_id;

   logic                g_vld;
   logic                g_last;
   logic [DATA_W-1:0]   g_data;
   logic                beat_fire;
   logic                cnt_limit;
   logic                wrap_id;

   // Only the granted port is muxed out, so X on any other port cannot reach the outputs.
   assign g_vld     = req_vld[grant_id];
   assign g_last    = req_last[grant_id];
   assign g_data    = req_data[int'(grant_id)*DATA_W +: DATA_W];
   assign beat_fire = (state == BURST) && g_vld && out_rdy;
   assign cnt_limit = ((beat_cnt + CNT_W'(1)) == CNT_W'(MAX_BURST));
   assign wrap_id   = (grant_id == ID_W'(NUM_REQ - 1));

   // Scanning from the highest offset down leaves the lowest offset from rr_ptr as the winner.
   always_comb begin
      pick_found = 1'b0;
      pick_id    = '0;
      scan_id    = '0;
      for (int k = NUM_REQ - 1; k >= 0; k--) begin
         scan_id = ID_W'((int'(rr_ptr) + k) % NUM_REQ);
         if (req_vld[scan_id]) begin
            pick_found = 1'b1;
            pick_id    = scan_id;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rstB) begin
         state     <= IDLE;
         rr_ptr    <= '0;
         grant_id  <= '0;
         beat_cnt  <= '0;
         burst_err <= 1'b0;
      end else begin
         state     <= state_n;
         rr_ptr    <= rr_n;
         grant_id  <= grant_n;
         beat_cnt  <= cnt_n;
         burst_err <= err_n;
      end
   end

   always_comb begin
      state_n  = state;
      rr_n     = rr_ptr;
      grant_n  = grant_id;
      cnt_n    = beat_cnt;
      err_n    = 1'b0;
      busy     = 1'b0;
      out_vld  = 1'b0;
      out_data = '0;
      req_rdy  = '0;

      case (state)
         IDLE: begin
            if (pick_found) begin
               state_n = BURST;
               grant_n = pick_id;
               cnt_n   = '0;
            end
         end

         BURST: begin
            busy              = 1'b1;
            out_vld           = g_vld;
            out_data          = g_data;
            req_rdy[grant_id] = out_rdy;
            if (beat_fire) begin
               // A beat carrying last ends normally even when it is also the MAX_BURST-th beat.
               if (g_last || cnt_limit) begin
                  state_n = IDLE;
                  rr_n    = wrap_id ? '0 : grant_id + ID_W'(1);
                  cnt_n   = '0;
                  err_n   = !g_last;
               end else begin
                  cnt_n = beat_cnt + CNT_W'(1);
               end
            end
         end

         default: state_n = IDLE;
      endcase
   end

endmodule
